// File: rtl/srx_deser32.sv
// rtl/srx_deser32.sv - LSB-first serial-to-parallel receiver with one-entry holding register
// Optional: define SRX_PARITY_EN to add a trailing even-parity bit per frame.
module srx_deser32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sin_bit,
    input  logic             sin_valid,
    input  logic             clear,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [CNT_W-1:0] bit_count,
    output logic             overrun,
    output logic             parity_err
);

    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] next_word;
    logic             complete;
    logic             load;

`ifdef SRX_PARITY_EN
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

    logic par_acc;
    logic perr_q;

    // The parity bit is not shifted in; the data word is already complete in shreg.
    assign next_word  = shreg;
    assign parity_err = perr_q;
`else
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    assign next_word  = {sin_bit, shreg[WIDTH-1:1]};
    assign parity_err = 1'b0;
`endif

    assign complete = sin_valid && !clear && (bit_count == LAST);
    assign load     = complete && (!word_valid || word_ready);

    always_ff @(posedge clock) begin
        if (reset) begin
            shreg      <= '0;
            bit_count  <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
`ifdef SRX_PARITY_EN
            par_acc    <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            if (clear) begin
                shreg     <= '0;
                bit_count <= '0;
                overrun   <= 1'b0;
`ifdef SRX_PARITY_EN
                par_acc   <= 1'b0;
                perr_q    <= 1'b0;
`endif
            end else if (sin_valid) begin
                if (complete) begin
                    bit_count <= '0;
`ifdef SRX_PARITY_EN
                    par_acc   <= 1'b0;
                    if (par_acc ^ sin_bit)
                        perr_q <= 1'b1;
`else
                    shreg     <= next_word;
`endif
                    if (!load)
                        overrun <= 1'b1;
                end else begin
                    shreg     <= {sin_bit, shreg[WIDTH-1:1]};
                    bit_count <= bit_count + 1'b1;
`ifdef SRX_PARITY_EN
                    par_acc   <= par_acc ^ sin_bit;
`endif
                end
            end

            // Holding register: load wins over accept so back-to-back words stay valid.
            if (load) begin
                word_out   <= next_word;
                word_valid <= 1'b1;
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_srx_deser32.sv
// tb/tb_srx_deser32.sv - self-checking bench for srx_deser32 against a bit-queue model
module tb_srx_deser32;

    localparam int W     = 32;
    localparam int CNT_W = 6;
`ifdef SRX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FRAME = W + PB;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             sin_bit = 1'b0;
    logic             sin_valid = 1'b0;
    logic             clear = 1'b0;
    logic             word_ready = 1'b0;
    logic [W-1:0]     word_out;
    logic             word_valid;
    logic [CNT_W-1:0] bit_count;
    logic             overrun;
    logic             parity_err;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    srx_deser32 #(.WIDTH(W), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .sin_bit    (sin_bit),
        .sin_valid  (sin_valid),
        .clear      (clear),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .bit_count  (bit_count),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clock = ~clock;

    // Reference: bits collected so far in a queue; a full frame becomes a word.
    bit           q[$];
    logic [W-1:0] m_word  = '0;
    bit           m_valid = 1'b0;
    bit           m_over  = 1'b0;
    bit           m_perr  = 1'b0;

    always @(posedge clock) begin
        bit           accept;
        bit           loaded;
        bit           px;
        logic [W-1:0] w;
        if (reset) begin
            q.delete();
            m_word  = '0;
            m_valid = 1'b0;
            m_over  = 1'b0;
            m_perr  = 1'b0;
        end else begin
            accept = m_valid && word_ready;
            loaded = 1'b0;
            if (clear) begin
                q.delete();
                m_over = 1'b0;
                m_perr = 1'b0;
            end else if (sin_valid) begin
                q.push_back(sin_bit);
                if (q.size() == FRAME) begin
                    w  = '0;
                    px = 1'b0;
                    for (int i = 0; i < FRAME; i++) begin
                        if (i < W) w[i] = q[i];
                        px = px ^ q[i];
                    end
                    if (PB == 1 && px) m_perr = 1'b1;
                    if (!m_valid || accept) begin
                        m_word  = w;
                        m_valid = 1'b1;
                        loaded  = 1'b1;
                    end else begin
                        m_over = 1'b1;
                    end
                    q.delete();
                end
            end
            if (accept && !loaded) m_valid = 1'b0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            check("word_out",   64'(word_out),   64'(m_word));
            check("word_valid", 64'(word_valid), 64'(m_valid));
            check("bit_count",  64'(bit_count),  64'(q.size()));
            check("overrun",    64'(overrun),    64'(m_over));
            check("parity_err", 64'(parity_err), 64'(m_perr));
        end
    end

    task automatic drive(input bit sv, input bit sb, input bit rdy, input bit clr, input bit rst);
        @(negedge clock);
        sin_valid  = sv;
        sin_bit    = sb;
        word_ready = rdy;
        clear      = clr;
        reset      = rst;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
    endtask

    // Sends one frame; rdy_last is the ready level on the completion cycle.
    task automatic send_word(input logic [W-1:0] w, input bit gap, input bit rdy,
                             input bit rdy_last, input bit par_flip);
        bit b;
        for (int i = 0; i < FRAME; i++) begin
            b = (i < W) ? w[i] : ((^w) ^ par_flip);
            drive(1, b, (i == FRAME - 1) ? rdy_last : rdy, 0, 0);
            if (gap) drive(0, 0, rdy, 0, 0);
        end
    endtask

    int vcnt;

    initial begin
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
        chk_en = 1'b1;
        check("reset_valid", 64'(word_valid), 64'd0);
        check("reset_word",  64'(word_out),   64'd0);

        send_word(32'hA5A50F01, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        check("t1_valid", 64'(word_valid), 64'd1);
        check("t1_word",  64'(word_out),   64'hA5A50F01);
        check("t1_count", 64'(bit_count),  64'd0);
        check("t1_over",  64'(overrun),    64'd0);

        do_reset();
        send_word(32'hA5A50F01, 1, 1, 1, 0);
        check("t2_word", 64'(word_out), 64'hA5A50F01);
        vcnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (word_valid) vcnt++;
            drive(0, 0, 1, 0, 0);
        end
        check("t2_pulses", 64'(vcnt), 64'd1);

        do_reset();
        send_word(32'h00000001, 0, 0, 0, 0);
        send_word(32'hFFFFFFFF, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        check("t3_word",  64'(word_out),   64'h1);
        check("t3_over",  64'(overrun),    64'd1);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0);
        check("t3_clr_over",  64'(overrun),    64'd0);
        check("t3_clr_valid", 64'(word_valid), 64'd1);

        send_word(32'h12345678, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0);
        check("t4_word",  64'(word_out),   64'h12345678);
        check("t4_valid", 64'(word_valid), 64'd1);
        check("t4_over",  64'(overrun),    64'd0);

        do_reset();
        for (int i = 0; i < 17; i++) drive(1, i[0], 0, 0, 0);
        drive(0, 0, 0, 0, 1);
        send_word(32'hDEADBEEF, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        check("t5_word", 64'(word_out), 64'hDEADBEEF);
        drive(0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) drive(1, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0);
        send_word(32'hDEADBEEF, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        check("t5c_word",  64'(word_out),   64'hDEADBEEF);
        check("t5c_valid", 64'(word_valid), 64'd1);

`ifdef SRX_PARITY_EN
        do_reset();
        send_word(32'h00000003, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        check("p1_perr", 64'(parity_err), 64'd0);
        send_word(32'h00000007, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
        check("p2_perr", 64'(parity_err), 64'd1);
        check("p2_word", 64'(word_out),   64'h7);
`endif

        do_reset();
        for (int i = 0; i < 4000; i++) begin
            drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
                  ($urandom_range(0, 99) == 0), ($urandom_range(0, 299) == 0));
        end
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
